// File: rtl/icmp_echo_responder_if.sv
// rtl/icmp_echo_responder_if.sv - ICMP receive / IP transmit signal bundle for icmp_echo_responder
//
// Purpose: groups the ICMP byte stream from the IP receive path, the received
// source address, the reply stream towards the IP transmit path and the
// status outputs into one bundle.
// Modports:
//   slave  - the responder: consumes i_*, drives o_*
//   master - the surrounding IP stack (or a bench): drives i_*, consumes o_*
// Signals:
//   i_icmp_data/len/last/valid  ICMP message bytes, length, last flag, strobe
//   i_recv_src_ip/valid         source IP of the received datagram and strobe
//   o_dst_ip/o_dst_ip_valid     reply destination IP, one-cycle strobe
//   o_send_data/type/len/last/valid  reply byte stream and its framing
//   o_busy, o_drop_cnt          status
interface icmp_echo_responder_if;
    logic [7:0]  i_icmp_data;
    logic [15:0] i_icmp_len;
    logic        i_icmp_last;
    logic        i_icmp_valid;
    logic [31:0] i_recv_src_ip;
    logic        i_recv_src_valid;
    logic [31:0] o_dst_ip;
    logic        o_dst_ip_valid;
    logic [7:0]  o_send_data;
    logic [7:0]  o_send_type;
    logic [15:0] o_send_len;
    logic        o_send_last;
    logic        o_send_valid;
    logic        o_busy;
    logic [15:0] o_drop_cnt;

    modport slave (
        input  i_icmp_data, i_icmp_len, i_icmp_last, i_icmp_valid,
        input  i_recv_src_ip, i_recv_src_valid,
        output o_dst_ip, o_dst_ip_valid,
        output o_send_data, o_send_type, o_send_len, o_send_last, o_send_valid,
        output o_busy, o_drop_cnt
    );

    modport master (
        output i_icmp_data, i_icmp_len, i_icmp_last, i_icmp_valid,
        output i_recv_src_ip, i_recv_src_valid,
        input  o_dst_ip, o_dst_ip_valid,
        input  o_send_data, o_send_type, o_send_len, o_send_last, o_send_valid,
        input  o_busy, o_drop_cnt
    );
endinterface

// File: rtl/icmp_echo_responder.sv
// rtl/icmp_echo_responder.sv - buffers ICMP echo requests and sends echo replies
//
// Purpose: receives ICMP messages from the IP receive path, keeps echo
// requests (type 8, code 0, length 8..P_BUF_DEPTH) in a byte buffer while
// summing the reply checksum, then emits the type-0 reply to the requester's
// source IP through the IP transmit path. Everything else is counted and
// discarded.
// Ports:
//   i_clk  - system clock
//   i_rst  - synchronous, active-low reset
//   bus    - icmp_echo_responder_if.slave (receive stream, source IP,
//            reply stream, busy, drop counter)
// Parameters:
//   P_BUF_DEPTH  - buffer size in bytes (power of two, >= 8)
//   P_ICMP_PROTO - protocol select driven on o_send_type
// Build option:
//   ICMP_CSUM_CHECK_EN - also verify the received checksum and drop requests
//                        whose folded sum is not 16'hFFFF
module icmp_echo_responder #(
    parameter int         P_BUF_DEPTH  = 1024,
    parameter logic [7:0] P_ICMP_PROTO = 8'd1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    icmp_echo_responder_if.slave  bus
);
    localparam int          AW      = $clog2(P_BUF_DEPTH);
    localparam logic [16:0] MAX_LEN = 17'(P_BUF_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_DROP,
        S_CSUM1,
        S_CSUM2,
        S_IP,
        S_SEND
    } state_t;

    state_t      state, state_nx;
    logic [15:0] len_q;
    logic [15:0] cnt_q;        // index of the byte currently being received
    logic [15:0] send_cnt;     // index of the reply byte currently on the bus
    logic [31:0] src_ip_q;
    logic [7:0]  hi_q;         // high byte of the word being assembled
    logic [31:0] sum_q;
    logic [15:0] csum_q;
    logic        busy_skip;    // inside a message that arrived while busy
    logic [15:0] drop_cnt_q;
    logic        drop_fsm;

    logic [7:0]  mem [P_BUF_DEPTH];
    logic [7:0]  rd_data;
    logic [AW-1:0] rd_addr;

`ifdef ICMP_CSUM_CHECK_EN
    logic [7:0]  chk_hi_q;
    logic [31:0] chk_sum_q;
`endif

    function automatic logic [31:0] fold1(input logic [31:0] x);
        return {16'd0, x[31:16]} + {16'd0, x[15:0]};
    endfunction

    // After one fold the value fits in 17 bits, so one more add cannot carry.
    function automatic logic [15:0] fold2(input logic [16:0] x);
        return x[15:0] + {15'd0, x[16]};
    endfunction

    logic busy_state;
    logic busy_path;
    logic take;
    logic len_ok;

    assign busy_state = (state == S_CSUM1) || (state == S_CSUM2) ||
                        (state == S_IP)    || (state == S_SEND);
    // A byte belongs to a discarded "busy" burst if the burst began while a
    // reply was in progress; such bursts are tracked until their last byte
    // even if the reply finishes in the meantime.
    assign busy_path  = bus.i_icmp_valid && (busy_skip || busy_state);
    assign take       = bus.i_icmp_valid && !busy_path;
    assign len_ok     = (bus.i_icmp_len >= 16'd8) && ({1'b0, bus.i_icmp_len} <= MAX_LEN);

    always_comb begin
        state_nx = state;
        drop_fsm = 1'b0;
        case (state)
            S_IDLE: begin
                if (take) begin
                    if (bus.i_icmp_last) begin
                        // A one-byte message can never meet the minimum length.
                        drop_fsm = 1'b1;
                    end else if (bus.i_icmp_data == 8'h08 && len_ok) begin
                        state_nx = S_RECV;
                    end else begin
                        state_nx = S_DROP;
                    end
                end
            end
            S_RECV: begin
                if (take) begin
                    if (bus.i_icmp_last) begin
                        // The message has ended, so a failure counts here
                        // rather than waiting in DROP for another last.
                        if (cnt_q + 16'd1 != len_q) begin
                            drop_fsm = 1'b1;
                            state_nx = S_IDLE;
                        end else begin
                            state_nx = S_CSUM1;
                        end
                    end else if (cnt_q == 16'd1 && bus.i_icmp_data != 8'h00) begin
                        state_nx = S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (take && bus.i_icmp_last) begin
                    drop_fsm = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_CSUM1: state_nx = S_CSUM2;
            S_CSUM2: begin
`ifdef ICMP_CSUM_CHECK_EN
                if (fold2(chk_sum_q[16:0]) != 16'hFFFF) begin
                    drop_fsm = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    state_nx = S_IP;
                end
`else
                state_nx = S_IP;
`endif
            end
            S_IP:   state_nx = S_SEND;
            S_SEND: begin
                if (send_cnt == len_q - 16'd1) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    logic [1:0]  drop_inc;
    logic [16:0] drop_sum;
    logic [31:0] pad_word;

    assign drop_inc = {1'b0, drop_fsm} + {1'b0, busy_path & bus.i_icmp_last};
    assign drop_sum = {1'b0, drop_cnt_q} + {15'd0, drop_inc};
    // Odd length: the final byte sits in hi_q as a high byte with low byte 0.
    assign pad_word = len_q[0] ? {16'd0, hi_q, 8'h00} : 32'd0;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state      <= S_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            send_cnt   <= '0;
            src_ip_q   <= '0;
            hi_q       <= '0;
            sum_q      <= '0;
            csum_q     <= '0;
            busy_skip  <= 1'b0;
            drop_cnt_q <= '0;
`ifdef ICMP_CSUM_CHECK_EN
            chk_hi_q   <= '0;
            chk_sum_q  <= '0;
`endif
        end else begin
            state      <= state_nx;
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (busy_path) begin
                busy_skip <= !bus.i_icmp_last;
            end
            if ((state == S_IDLE || state == S_RECV) && bus.i_recv_src_valid) begin
                src_ip_q <= bus.i_recv_src_ip;
            end
            case (state)
                S_IDLE: begin
                    if (take) begin
                        len_q <= bus.i_icmp_len;
                        cnt_q <= 16'd1;
                        sum_q <= '0;
                        hi_q  <= 8'h00;     // type byte is replaced by 0
`ifdef ICMP_CSUM_CHECK_EN
                        chk_hi_q  <= bus.i_icmp_data;
                        chk_sum_q <= '0;
`endif
                    end
                end
                S_RECV: begin
                    if (take) begin
                        cnt_q <= cnt_q + 16'd1;
                        if (!cnt_q[0]) begin
                            hi_q <= (cnt_q == 16'd2) ? 8'h00 : bus.i_icmp_data;
                        end else begin
                            sum_q <= sum_q + {16'd0, hi_q,
                                              (cnt_q == 16'd3) ? 8'h00 : bus.i_icmp_data};
                        end
`ifdef ICMP_CSUM_CHECK_EN
                        if (!cnt_q[0]) begin
                            chk_hi_q <= bus.i_icmp_data;
                        end else begin
                            chk_sum_q <= chk_sum_q + {16'd0, chk_hi_q, bus.i_icmp_data};
                        end
`endif
                    end
                end
                S_CSUM1: begin
                    sum_q <= fold1(sum_q + pad_word);
`ifdef ICMP_CSUM_CHECK_EN
                    chk_sum_q <= fold1(chk_sum_q +
                                       (len_q[0] ? {16'd0, chk_hi_q, 8'h00} : 32'd0));
`endif
                end
                S_CSUM2: csum_q   <= ~fold2(sum_q[16:0]);
                S_IP:    send_cnt <= '0;
                S_SEND:  send_cnt <= send_cnt + 16'd1;
                default: ;
            endcase
        end
    end

    // Read address runs one byte ahead of the reply index so the registered
    // buffer output lines up with it; byte 4 is requested from IP onwards.
    assign rd_addr = (state == S_SEND && send_cnt >= 16'd3) ?
                     (send_cnt[AW-1:0] + AW'(1)) : AW'(4);

    always_ff @(posedge i_clk) begin
        if (state == S_RECV && take) begin
            mem[cnt_q[AW-1:0]] <= bus.i_icmp_data;
        end
        rd_data <= mem[rd_addr];
    end

    always_comb begin
        bus.o_dst_ip       = (state == S_IP) ? src_ip_q : 32'd0;
        bus.o_dst_ip_valid = (state == S_IP);
        bus.o_send_valid   = (state == S_SEND);
        bus.o_send_type    = (state == S_SEND) ? P_ICMP_PROTO : 8'd0;
        bus.o_send_len     = (state == S_SEND) ? len_q : 16'd0;
        bus.o_send_last    = (state == S_SEND) && (send_cnt == len_q - 16'd1);
        bus.o_send_data    = 8'd0;
        if (state == S_SEND) begin
            if (send_cnt == 16'd2) begin
                bus.o_send_data = csum_q[15:8];
            end else if (send_cnt == 16'd3) begin
                bus.o_send_data = csum_q[7:0];
            end else if (send_cnt >= 16'd4) begin
                bus.o_send_data = rd_data;
            end
        end
        bus.o_busy     = (state != S_IDLE);
        bus.o_drop_cnt = drop_cnt_q;
    end
endmodule

// File: tb/tb_icmp_echo_responder.sv
// tb/tb_icmp_echo_responder.sv - self-checking bench for icmp_echo_responder
module tb_icmp_echo_responder;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    icmp_echo_responder_if bus();

    icmp_echo_responder #(
        .P_BUF_DEPTH  (DEPTH),
        .P_ICMP_PROTO (8'd1)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        int          cyc;
        logic [7:0]  data;
        logic        last;
        logic [15:0] len;
    } exp_byte_t;

    typedef struct {
        int          cyc;
        logic [31:0] ip;
    } exp_ip_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    exp_byte_t   exp_q[$];
    exp_ip_t     ip_q[$];
    exp_byte_t   e;
    logic [7:0]  cap[$];
    logic [31:0] cap_ip = 32'd0;
    logic [7:0]  msg[$];
    int          busy_lo = -1;
    int          busy_hi = -2;
    int          exp_drop = 0;
    logic        prev_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One's-complement sum over big-endian words; without 'full' the type
    // byte and the checksum field are taken as zero.
    function automatic logic [15:0] ones_sum(input logic [7:0] m[$], input bit full);
        int unsigned s = 0;
        for (int i = 0; i < m.size(); i += 2) begin
            int unsigned hi = m[i];
            int unsigned lo = (i + 1 < m.size()) ? m[i+1] : 0;
            if (!full && i == 0) hi = 0;
            if (!full && i == 2) begin hi = 0; lo = 0; end
            s += hi * 256 + lo;
        end
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return s[15:0];
    endfunction

    // Valid echo request of n bytes with a correct checksum field.
    task automatic make_req(input int n, input int seed);
        logic [15:0] cs;
        msg.delete();
        msg.push_back(8'h08);
        msg.push_back(8'h00);
        msg.push_back(8'h00);
        msg.push_back(8'h00);
        for (int i = 4; i < n; i++) msg.push_back(8'((i * 37 + seed) & 255));
        cs = ~ones_sum(msg, 1'b1);
        msg[2] = cs[15:8];
        msg[3] = cs[7:0];
    endtask

    task automatic model_decide(input logic [15:0] len_field, input int ts, input int te,
                                input logic [31:0] ip);
        int n = msg.size();
        bit ok;
        logic [15:0] cs;
        exp_ip_t xi;
        exp_byte_t xb;
        if (ts >= busy_lo && ts <= busy_hi) ok = 0;
        else if (msg[0] != 8'h08 || int'(len_field) < 8 || int'(len_field) > DEPTH) ok = 0;
        else if (n < 2 || msg[1] != 8'h00) ok = 0;
        else if (n != int'(len_field)) ok = 0;
`ifdef ICMP_CSUM_CHECK_EN
        else if (ones_sum(msg, 1'b1) != 16'hFFFF) ok = 0;
`endif
        else ok = 1;
        if (!ok) begin
            exp_drop++;
        end else begin
            cs = ~ones_sum(msg, 1'b0);
            xi.cyc = te + 3;
            xi.ip  = ip;
            ip_q.push_back(xi);
            for (int i = 0; i < n; i++) begin
                xb.cyc  = te + 4 + i;
                xb.data = (i < 2) ? 8'h00 : (i == 2) ? cs[15:8] : (i == 3) ? cs[7:0] : msg[i];
                xb.last = (i == n - 1);
                xb.len  = 16'(n);
                exp_q.push_back(xb);
            end
            busy_lo = te + 1;
            busy_hi = te + 4 + n - 1;
        end
    endtask

    task automatic send_msg(input logic [15:0] len_field, input logic [31:0] ip);
        int ts;
        int te;
        @(posedge clk); #1;
        ts = cyc;
        for (int i = 0; i < msg.size(); i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            bus.i_icmp_valid     = 1'b1;
            bus.i_icmp_data      = msg[i];
            bus.i_icmp_len       = len_field;
            bus.i_icmp_last      = (i == msg.size() - 1);
            bus.i_recv_src_ip    = ip;
            bus.i_recv_src_valid = (i == 0);
        end
        te = cyc;
        @(posedge clk); #1;
        bus.i_icmp_valid     = 1'b0;
        bus.i_icmp_last      = 1'b0;
        bus.i_icmp_data      = 8'h00;
        bus.i_recv_src_valid = 1'b0;
        model_decide(len_field, ts, te, ip);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((exp_q.size() != 0 || ip_q.size() != 0 || bus.o_busy) && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        check("wait_idle_timeout", 64'(k >= 3000), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bus.o_dst_ip_valid) begin
                if (ip_q.size() == 0) begin
                    check("unexpected_ip_valid", 64'd1, 64'd0);
                end else begin
                    check("ip_cycle", 64'(ip_q[0].cyc), 64'(cyc));
                    check("dst_ip", 64'(bus.o_dst_ip), 64'(ip_q[0].ip));
                    cap_ip = bus.o_dst_ip;
                    void'(ip_q.pop_front());
                end
            end else if (ip_q.size() != 0 && ip_q[0].cyc <= cyc) begin
                check("ip_missing", 64'd0, 64'd1);
                void'(ip_q.pop_front());
            end

            if (bus.o_send_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_send_valid", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("send_cycle", 64'(cyc), 64'(e.cyc));
                    check("send_byte", 64'({bus.o_send_data, bus.o_send_last, bus.o_send_len}),
                          64'({e.data, e.last, e.len}));
                    check("send_type", 64'(bus.o_send_type), 64'd1);
                    cap.push_back(bus.o_send_data);
                end
            end else begin
                if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                    check("send_missing", 64'd0, 64'd1);
                    void'(exp_q.pop_front());
                end
                check("idle_send_outputs",
                      64'({bus.o_send_data, bus.o_send_last, bus.o_send_len, bus.o_send_type}), 64'd0);
            end
            if (prev_last) check("busy_after_last", 64'(bus.o_busy), 64'd0);
            prev_last = bus.o_send_valid & bus.o_send_last;
        end else begin
            prev_last = 1'b0;
        end
    end

    initial begin
        int d;
        int k;
        bus.i_icmp_data      = 8'h00;
        bus.i_icmp_len       = 16'd0;
        bus.i_icmp_last      = 1'b0;
        bus.i_icmp_valid     = 1'b0;
        bus.i_recv_src_ip    = 32'd0;
        bus.i_recv_src_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({bus.o_send_valid, bus.o_dst_ip_valid, bus.o_busy, bus.o_drop_cnt,
                                    bus.o_send_data, bus.o_send_len}), 64'd0);
        check("reset_dst_ip", 64'(bus.o_dst_ip), 64'd0);
        rst = 1'b1;

        // Basic 40-byte echo with the literal checksum 16'h4D5A.
        msg.delete();
        for (int i = 0; i < 40; i++) msg.push_back(8'h00);
        msg[0] = 8'h08; msg[2] = 8'h4D; msg[3] = 8'h5A;
        msg[4] = 8'hAA; msg[5] = 8'hA5; msg[6] = 8'h12; msg[7] = 8'h34;
        msg[8] = 8'hED; msg[9] = 8'hCB;
        check("model_basic_req_sum", 64'(ones_sum(msg, 1'b1)), 64'hFFFF);
        cap.delete();
        send_msg(16'd40, 32'hC0A8010A);
        wait_idle();
        check("basic_len", 64'(cap.size()), 64'd40);
        if (cap.size() == 40) begin
            check("basic_hdr", 64'({cap[0], cap[1], cap[2], cap[3]}), 64'h0000555A);
            check("basic_payload", 64'({cap[4], cap[5], cap[39]}), 64'hAAA500);
        end
        check("basic_ip", 64'(cap_ip), 64'hC0A8010A);
        check("basic_drop", 64'(bus.o_drop_cnt), 64'd0);

        // Odd length: final byte 8'hAB is the high byte of the last word.
        msg.push_back(8'hAB);
        msg[2] = 8'hA2; msg[3] = 8'h59;
        check("model_odd_req_sum", 64'(ones_sum(msg, 1'b1)), 64'hFFFF);
        cap.delete();
        send_msg(16'd41, 32'h0A000001);
        wait_idle();
        check("odd_len", 64'(cap.size()), 64'd41);
        if (cap.size() == 41) begin
            check("odd_csum", 64'({cap[2], cap[3]}), 64'hAA59);
            check("odd_last_byte", 64'(cap[40]), 64'hAB);
        end
        check("odd_reply_verifies", 64'(ones_sum(cap, 1'b1)), 64'hFFFF);

        // Filtering: type 0, oversize, length mismatch.
        make_req(8, 3);
        msg[0] = 8'h00;
        send_msg(16'd8, 32'h01020304);
        wait_idle();
        check("drop_type0", 64'(bus.o_drop_cnt), 64'd1);

        make_req(1500, 5);
        send_msg(16'd1500, 32'h01020304);
        wait_idle();
        check("drop_oversize", 64'(bus.o_drop_cnt), 64'd2);

        make_req(16, 7);
        send_msg(16'd20, 32'h01020304);
        wait_idle();
        check("drop_mismatch", 64'(bus.o_drop_cnt), 64'd3);

        // Non-zero code, then a lone byte that already carries last.
        make_req(8, 9);
        msg[1] = 8'h01;
        send_msg(16'd8, 32'h01020304);
        wait_idle();
        check("drop_code", 64'(bus.o_drop_cnt), 64'(exp_drop));

        msg.delete();
        msg.push_back(8'h08);
        send_msg(16'd8, 32'h01020304);
        wait_idle();
        check("drop_single", 64'(bus.o_drop_cnt), 64'd5);

        // Minimum accepted length.
        make_req(8, 11);
        cap.delete();
        send_msg(16'd8, 32'hAC100001);
        wait_idle();
        check("min_len", 64'(cap.size()), 64'd8);

        // Busy: second request starts 5 cycles into the first reply.
        make_req(40, 13);
        cap.delete();
        send_msg(16'd40, 32'hC0A80002);
        k = 0;
        while (!bus.o_send_valid && k < 20) begin @(posedge clk); #1; k++; end
        check("busy_reply_start", 64'(bus.o_send_valid), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        d = exp_drop;
        make_req(40, 17);
        send_msg(16'd40, 32'hC0A80003);
        wait_idle();
        check("busy_drop", 64'(bus.o_drop_cnt), 64'(d + 1));
        check("busy_first_reply_len", 64'(cap.size()), 64'd40);

        // New message starts in the cycle of the reply's last byte.
        make_req(12, 19);
        send_msg(16'd12, 32'hC0A80004);
        k = 0;
        while (cyc != busy_hi - 1 && k < 100) begin @(posedge clk); #1; k++; end
        d = exp_drop;
        make_req(8, 23);
        send_msg(16'd8, 32'hC0A80005);
        wait_idle();
        check("simultaneous_drop", 64'(bus.o_drop_cnt), 64'(d + 1));

        // Reset while the 10th reply byte is on the bus.
        make_req(30, 29);
        send_msg(16'd30, 32'hC0A80006);
        cap.delete();
        k = 0;
        while (cap.size() < 9 && k < 60) begin @(posedge clk); #1; k++; end
        check("reset_point_reached", 64'(cap.size()), 64'd9);
        rst = 1'b0;
        exp_q.delete();
        ip_q.delete();
        busy_lo = -1;
        busy_hi = -2;
        exp_drop = 0;
        @(posedge clk); #1;
        check("midsend_reset_outputs", 64'({bus.o_send_valid, bus.o_send_last, bus.o_dst_ip_valid,
                                            bus.o_busy, bus.o_drop_cnt, bus.o_send_data}), 64'd0);
        check("midsend_reset_len", 64'({bus.o_send_len, bus.o_send_type}), 64'd0);
        rst = 1'b1;
        make_req(20, 31);
        cap.delete();
        send_msg(16'd20, 32'hC0A80007);
        wait_idle();
        check("post_reset_len", 64'(cap.size()), 64'd20);
        check("post_reset_verifies", 64'(ones_sum(cap, 1'b1)), 64'hFFFF);

        // Corrupted checksum field, then the same request intact.
        make_req(24, 37);
        msg[2] = 8'h00;
        msg[3] = 8'h00;
        d = exp_drop;
        cap.delete();
        send_msg(16'd24, 32'hC0A80008);
        wait_idle();
`ifdef ICMP_CSUM_CHECK_EN
        check("corrupt_drop", 64'(bus.o_drop_cnt), 64'(d + 1));
        check("corrupt_no_reply", 64'(cap.size()), 64'd0);
`else
        check("corrupt_ignored", 64'(cap.size()), 64'd24);
`endif
        make_req(24, 37);
        cap.delete();
        send_msg(16'd24, 32'hC0A80008);
        wait_idle();
        check("intact_reply", 64'(cap.size()), 64'd24);

        check("final_drop", 64'(bus.o_drop_cnt), 64'(exp_drop));
        check("final_queues_empty", 64'(exp_q.size() + ip_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/icmp_echo_responder.md
Name: icmp_echo_responder

Overview:
- Sits downstream of the IP receive path's ICMP output and upstream of the IP transmit send port.
- Buffers each ICMP echo request (type 8, code 0) and computes the reply checksum while receiving.
- Then emits a complete echo reply (type 0) back into the IP transmit path, addressed to the requester's source IP.
- All other ICMP traffic is discarded.

Parameters:
- P_BUF_DEPTH, 1024: payload buffer size in bytes (power of two); maximum ICMP message length accepted.
- P_ICMP_PROTO, 8'd1: value driven on o_send_type to select ICMP in the IP transmit path.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  synchronous, active-low reset.
- i_icmp_data  input  8  ICMP message byte from the IP receive path.
- i_icmp_len  input  16  ICMP message length in bytes, stable while i_icmp_valid.
- i_icmp_last  input  1  last byte of the ICMP message.
- i_icmp_valid  input  1  byte strobe.
- i_recv_src_ip  input  32  source IP of the received datagram.
- i_recv_src_valid  input  1  strobe for i_recv_src_ip.
- o_dst_ip  output  32  destination IP for the reply.
- o_dst_ip_valid  output  1  one-cycle strobe for o_dst_ip.
- o_send_data  output  8  reply byte.
- o_send_type  output  8  protocol select, equal to P_ICMP_PROTO.
- o_send_len  output  16  reply length in bytes.
- o_send_last  output  1  last reply byte.
- o_send_valid  output  1  reply byte strobe.
- o_busy  output  1  high in every state except IDLE.
- o_drop_cnt  output  16  count of discarded messages.

Behaviour:
- Reset (i_rst=0 at a clock edge):
  - All outputs go to 0; o_drop_cnt goes to 0.
  - State returns to IDLE and the buffer write/read pointers clear.
  - This applies mid-receive or mid-send; a partial reply is truncated with no o_send_last.
- Source IP latch: i_recv_src_ip is latched on i_recv_src_valid in IDLE or RECV only.
- IDLE: on the first i_icmp_valid:
  - Go to RECV if byte==8'h08 and i_icmp_len is in the range 8..P_BUF_DEPTH.
  - Otherwise go to DROP.
  - Latch i_icmp_len either way.
- RECV:
  - Write each byte to the buffer at index count.
  - Accumulate a 32-bit one's-complement sum over 16-bit big-endian words, substituting 0 for byte 0 (type) and bytes 2-3 (checksum).
  - Byte 1 (code) must be 0, else go to DROP.
  - On i_icmp_last: if count+1 != latched length, go to DROP; else go to CSUM.
- DROP:
  - Consume bytes until i_icmp_last, then increment o_drop_cnt (saturating at 16'hFFFF) and return to IDLE.
  - If entered on a single-byte message whose first byte already carries last, increment and return to IDLE the same cycle.
- CSUM, 2 cycles:
  - Odd length: the final byte is the high byte, low byte 0.
  - Fold the carries twice, then invert to get the 16-bit reply checksum.
- IP, 1 cycle:
  - o_dst_ip = latched source IP, o_dst_ip_valid=1.
  - Issue the buffer read of byte 4 (the buffer has 1-cycle read latency).
- SEND:
  - o_send_valid=1 for exactly len consecutive cycles with no gaps.
  - Byte order: 8'h00, 8'h00, checksum[15:8], checksum[7:0], then buffer bytes 4..len-1.
  - o_send_len = len and o_send_type = P_ICMP_PROTO, held for the whole burst.
  - o_send_last is asserted on byte len-1; then return to IDLE.
- Latency: i_icmp_last accepted at cycle T → o_dst_ip_valid at T+3 → first o_send_valid at T+4.
- Busy drop: any i_icmp_valid burst that starts while in CSUM, IP or SEND is discarded whole and increments o_drop_cnt once at its last byte. The in-progress reply is not disturbed.
- Simultaneous event: a new message starting in the same cycle the reply's last byte is sent counts as busy and is dropped.
- Outside SEND, o_send_* and o_send_valid are 0.

Optional Feature:
- Macro ICMP_CSUM_CHECK_EN.
- When defined:
  - RECV additionally accumulates the true request sum, including type and the received checksum field.
  - In CSUM, a folded result != 16'hFFFF sends the message to IDLE with o_drop_cnt+1 and no reply.
- When undefined: the received checksum is ignored. Latency is identical in both builds.

Test Plan:
- Basic echo: 40-byte request (type 08, code 00, checksum 16'h4D5A, consistent payload), src 192.168.1.10 → o_dst_ip=32'hC0A8010A at T+3; 40 bytes from T+4 starting 00 00 55 5A; payload bytes match; o_send_last on byte 40; o_send_len=40; o_send_type=1.
- Odd length: 41-byte request with last payload byte 8'hAB → checksum treats the final word as 16'hAB00; reply is 41 bytes and its checksum verifies to 16'hFFFF.
- Filtering:
  - Type-0 message → no output, o_drop_cnt=1.
  - Length 1500 with P_BUF_DEPTH=1024 → no output, o_drop_cnt=2.
  - Length-mismatch message → o_drop_cnt=3.
- Busy: second request started 5 cycles into the first reply's SEND → first reply completes unaltered, no second reply, o_drop_cnt+1, o_busy low after o_send_last.
- Reset mid-send: i_rst=0 for 1 cycle at byte 10 of the reply → next cycle all outputs 0, o_drop_cnt=0; a fresh request then gets a correct reply.
- ICMP_CSUM_CHECK_EN build: request with corrupted checksum 16'h0000 → no reply, o_drop_cnt=1; the same request with the correct checksum → reply.
